// File: rtl/alu_pipe.sv
// alu_pipe: valid/ready pipelined ALU with registered flags; define ALU_MUL_EN to build the iterative multiplier.
module alu_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic             illegal
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state;

    logic             accept, start_mul, mul_done, mul_c;
    logic [WIDTH-1:0] mul_y, res_y;
    logic             res_c, res_v, res_i;
    logic [WIDTH:0]   sum, dif, sl, sr, sa;
    logic [SHW-1:0]   sh;

    assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
    assign out_valid = state == DONE;
    assign accept    = in_valid & in_ready;
    assign zero      = y == '0;
    assign negative  = y[WIDTH-1];

    assign sh  = b[SHW-1:0];
    assign sum = {1'b0, a} + {1'b0, b};
    assign dif = {1'b0, a} + {1'b0, ~b} + 1'b1;
    // Shifts run one bit wider so the last bit shifted out lands in the spare bit.
    assign sl  = {1'b0, a} << sh;
    assign sr  = {a, 1'b0} >> sh;
    assign sa  = $signed({a, 1'b0}) >>> sh;

    always_comb begin
        res_y = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        res_i = 1'b0;
        case (op)
            4'h0: begin
                res_y = sum[WIDTH-1:0];
                res_c = sum[WIDTH];
                res_v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            4'h1: begin
                res_y = dif[WIDTH-1:0];
                res_c = dif[WIDTH];
                res_v = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
            end
            4'h2: res_y = a & b;
            4'h3: res_y = a | b;
            4'h4: res_y = a ^ b;
            4'h5: begin
                res_y = sl[WIDTH-1:0];
                res_c = sl[WIDTH];
            end
            4'h6: begin
                res_y = sr[WIDTH:1];
                res_c = sr[0];
            end
            4'h7: begin
                res_y = sa[WIDTH:1];
                res_c = sa[0];
            end
            4'h8: res_y = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            4'h9: res_y = {{(WIDTH-1){1'b0}}, a < b};
            default: res_i = 1'b1;
        endcase
    end

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] acc, mcand, acc_nxt;
    logic [WIDTH-1:0]   mplier;
    logic [SHW-1:0]     cnt;

    assign start_mul = op == 4'hA;
    assign acc_nxt   = mplier[0] ? acc + mcand : acc;
    assign mul_done  = (state == BUSY) && (cnt == '0);
    assign mul_y     = acc_nxt[WIDTH-1:0];
    assign mul_c     = |acc_nxt[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (accept) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            cnt    <= SHW'(WIDTH - 1);
        end else if (state == BUSY) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - 1'b1;
        end
    end
`else
    assign start_mul = 1'b0;
    assign mul_done  = 1'b0;
    assign mul_y     = '0;
    assign mul_c     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            y        <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            illegal  <= 1'b0;
        end else if (accept && start_mul) begin
            state <= BUSY;
        end else if (accept) begin
            state    <= DONE;
            y        <= res_y;
            carry    <= res_c;
            overflow <= res_v;
            illegal  <= res_i;
        end else if (mul_done) begin
            state    <= DONE;
            y        <= mul_y;
            carry    <= mul_c;
            overflow <= 1'b0;
            illegal  <= 1'b0;
        end else if (state == DONE && out_ready) begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed vectors, back-pressure/reset sequences and randomized ops against a reference model.
module tb_alu_pipe;
    logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready;
    logic        carry, overflow, zero, negative, illegal;
    logic [31:0] a, b, y;
    logic [3:0]  op;
    int          checks = 0;
    int          failures = 0;

`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, y;
        logic        c, v, z, n, i;
    } vec_t;

    alu_pipe #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .carry(carry), .overflow(overflow), .zero(zero),
        .negative(negative), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] w);
        vec_t r;
        longint xs, ws, s;
        logic [63:0] u;
        int sh;
        longint hi = (longint'(1) << 31) - 1;
        longint lo = -(longint'(1) << 31);
        xs = $signed(x);
        ws = $signed(w);
        sh = int'(w % 32);
        r.op = o; r.a = x; r.b = w; r.y = '0; r.c = 0; r.v = 0; r.i = 0;
        case (o)
            4'd0: begin
                u = {32'b0, x} + {32'b0, w};
                r.y = u[31:0]; r.c = u[32];
                s = xs + ws; r.v = (s > hi) || (s < lo);
            end
            4'd1: begin
                r.y = x - w; r.c = x >= w;
                s = xs - ws; r.v = (s > hi) || (s < lo);
            end
            4'd2: r.y = x & w;
            4'd3: r.y = x | w;
            4'd4: r.y = x ^ w;
            4'd5: begin
                r.y = x << sh;
                r.c = (sh != 0) && (((x >> (32 - sh)) & 32'd1) != 0);
            end
            4'd6: begin
                r.y = x >> sh;
                r.c = (sh != 0) && (((x >> (sh - 1)) & 32'd1) != 0);
            end
            4'd7: begin
                r.y = $signed(x) >>> sh;
                r.c = (sh != 0) && (((x >> (sh - 1)) & 32'd1) != 0);
            end
            4'd8: r.y = (xs < ws) ? 32'd1 : 32'd0;
            4'd9: r.y = (x < w) ? 32'd1 : 32'd0;
            4'd10: begin
                if (MUL_EN) begin
                    u = {32'b0, x} * {32'b0, w};
                    r.y = u[31:0]; r.c = u[63:32] != 0;
                end else r.i = 1;
            end
            default: r.i = 1;
        endcase
        r.z = r.y == 0;
        r.n = r.y[31];
        return r;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'h7FFFFFFF;
            4: return $urandom_range(0, 40);
            default: return $urandom;
        endcase
    endfunction

    task automatic check_out(input vec_t e, input string nm);
        chk({nm, ".y"}, y, e.y);
        chk({nm, ".carry"}, carry, e.c);
        chk({nm, ".overflow"}, overflow, e.v);
        chk({nm, ".zero"}, zero, e.z);
        chk({nm, ".negative"}, negative, e.n);
        chk({nm, ".illegal"}, illegal, e.i);
    endtask

    task automatic run_op(input vec_t e, input string nm);
        int n;
        int lat;
        lat = (e.op == 4'hA && MUL_EN) ? 32 : 0;
        out_ready = 1; in_valid = 1; op = e.op; a = e.a; b = e.b;
        n = 0;
        while (!in_ready && n < 100) begin tick(); n++; end
        chk({nm, ".accept_wait"}, n < 100, 1);
        tick();
        in_valid = 0; op = 4'($urandom); a = $urandom; b = $urandom;
        n = 0;
        while (!out_valid && n < 100) begin
            chk({nm, ".busy_in_ready"}, in_ready, 0);
            tick();
            n++;
        end
        chk({nm, ".latency"}, n, lat);
        check_out(e, nm);
    endtask

    vec_t tbl [18];

    initial begin
        vec_t held;
        tbl[0]  = '{4'h0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 0, 1, 0, 0};
        tbl[1]  = '{4'h1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1, 1, 0, 0, 0};
        tbl[2]  = '{4'h7, 32'h80000000, 32'h00000004, 32'hF8000000, 0, 0, 0, 1, 0};
        tbl[3]  = '{4'h5, 32'h80000001, 32'h00000001, 32'h00000002, 1, 0, 0, 0, 0};
        tbl[4]  = '{4'h8, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 0, 0, 0, 0, 0};
        tbl[5]  = '{4'h9, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 0, 0, 1, 0, 0};
        tbl[6]  = '{4'h4, 32'hF0F0F0F0, 32'hFFFFFFFF, 32'h0F0F0F0F, 0, 0, 0, 0, 0};
        tbl[7]  = '{4'hC, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 0, 0, 1, 0, 1};
        tbl[8]  = '{4'h6, 32'h00000081, 32'h00000020, 32'h00000081, 0, 0, 0, 0, 0};
        tbl[9]  = '{4'h1, 32'h00000001, 32'h00000002, 32'hFFFFFFFF, 0, 0, 0, 1, 0};
        tbl[10] = '{4'h0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 1, 0, 1, 0};
        tbl[11] = '{4'h2, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 0, 0, 0, 0, 0};
        tbl[12] = '{4'h3, 32'hFF00FF00, 32'h0FF00FF0, 32'hFFF0FFF0, 0, 0, 0, 1, 0};
        tbl[13] = '{4'h6, 32'h80000001, 32'h00000001, 32'h40000000, 1, 0, 0, 0, 0};
        tbl[14] = '{4'h7, 32'h80000001, 32'h00000001, 32'hC0000000, 1, 0, 0, 1, 0};
`ifdef ALU_MUL_EN
        tbl[15] = '{4'hA, 32'h00010000, 32'h00010000, 32'h00000000, 1, 0, 1, 0, 0};
`else
        tbl[15] = '{4'hA, 32'h00010000, 32'h00010000, 32'h00000000, 0, 0, 1, 0, 1};
`endif
        tbl[16] = '{4'h5, 32'h00000001, 32'h0000001F, 32'h80000000, 0, 0, 0, 1, 0};
        tbl[17] = '{4'h0, 32'h80000000, 32'h80000000, 32'h00000000, 1, 1, 1, 0, 0};

        rst_n = 0; in_valid = 0; out_ready = 1; op = 0; a = 0; b = 0;
        tick(); tick();
        chk("rst.out_valid", out_valid, 0);
        chk("rst.in_ready", in_ready, 1);
        chk("rst.y", y, 0);
        chk("rst.zero", zero, 1);
        chk("rst.flags", {carry, overflow, negative, illegal}, 0);
        rst_n = 1;
        tick();

        for (int i = 0; i < 18; i++) run_op(tbl[i], $sformatf("vec%0d", i));

        in_valid = 0;
        tick();
        chk("drain.out_valid", out_valid, 0);
        chk("drain.in_ready", in_ready, 1);

        // Back-pressure: result must hold while the consumer stalls.
        out_ready = 0; in_valid = 1; op = 4'h0; a = 32'd5; b = 32'd3;
        tick();
        held = model(4'h0, 32'd5, 32'd3);
        op = 4'h1; a = 32'd9; b = 32'd9;
        for (int i = 0; i < 3; i++) begin
            chk("bp.out_valid", out_valid, 1);
            chk("bp.in_ready", in_ready, 0);
            check_out(held, "bp");
            tick();
        end
        out_ready = 1; op = 4'h4; a = 32'hF0F0F0F0; b = 32'hFFFFFFFF;
        #1;
        chk("bp.in_ready_comb", in_ready, 1);
        tick();
        in_valid = 0;
        chk("bp.no_gap", out_valid, 1);
        check_out(model(4'h4, 32'hF0F0F0F0, 32'hFFFFFFFF), "bp_next");
        tick();
        chk("bp.drain", out_valid, 0);

        // Reset in the middle of a multiply.
        run_op(model(4'h0, 32'd1, 32'd1), "pre_rst");
        in_valid = 1; op = 4'hA; a = 32'h00010000; b = 32'h00010000;
        tick();
        in_valid = 0;
        for (int i = 0; i < 5; i++) tick();
        rst_n = 0;
        tick();
        rst_n = 1;
        chk("midrst.out_valid", out_valid, 0);
        chk("midrst.in_ready", in_ready, 1);
        chk("midrst.zero", zero, 1);
        chk("midrst.y", y, 0);
        chk("midrst.flags", {carry, overflow, negative, illegal}, 0);
        tick();
        chk("midrst.idle", out_valid, 0);
        run_op(model(4'hC, 32'hDEADBEEF, 32'h1), "post_rst_illegal");

        for (int i = 0; i < 150; i++) begin
            logic [3:0]  o;
            logic [31:0] x, w;
            o = 4'($urandom_range(0, 15));
            x = pick();
            w = pick();
            run_op(model(o, x, w), $sformatf("rnd%0d_op%0h", i, o));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_pipe.md
# alu_pipe

Registered, handshaked successor to the team's combinational ALU, parametrised in `WIDTH`. It keeps the original opcode map (ADD/SUB/AND/OR/XOR) and adds shifts, signed/unsigned compares and an optional iterative multiplier. Operands enter on a valid/ready input channel. Results and flags leave on a valid/ready output channel. The block sits between operand fetch and write-back, so back-pressure from write-back stalls issue.

## Interface
- `WIDTH`, 32: datapath width; power of two, ≥ 8. `SHW = $clog2(WIDTH)` is derived.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `in_valid`  in  1  operand/op presented.
- `in_ready`  out  1  block accepts the operation this cycle.
- `a`, `b`  in  WIDTH  operands.
- `op`  in  4  opcode.
- `out_valid`  out  1  result registers hold a valid result.
- `out_ready`  in  1  consumer takes the result this cycle.
- `y`  out  WIDTH  result.
- `carry`, `overflow`, `zero`, `negative`  out  1 each  result flags.
- `illegal`  out  1  the accepted opcode was unsupported.

## Operation
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, A MUL.
  - B–F are illegal.
- ADD computes `{0,a}+{0,b}` in WIDTH+1 bits.
  - `carry` = bit WIDTH.
  - `overflow` = operand signs equal and result sign differs.
- SUB computes `a + ~b + 1` in WIDTH+1 bits.
  - `carry` = bit WIDTH, so it is 1 when a ≥ b unsigned (no borrow).
  - `overflow` = operand signs differ and result sign differs from `a`.
- AND/OR/XOR: `carry` = `overflow` = 0.
- Shifts use shift amount `b[SHW-1:0]`; upper bits of `b` are ignored.
  - SRA sign-fills.
  - `carry` = the last bit shifted out; 0 when the shift amount is 0.
  - `overflow` = 0.
- SLT/SLTU: `y` = `{0…, a<b}`, signed or unsigned compare respectively; `carry` = `overflow` = 0.
- MUL (only with `ALU_MUL_EN`):
  - Iterative shift-add, one bit of `b` per cycle.
  - `y` = low WIDTH bits of the unsigned product.
  - `carry` = OR of the high WIDTH product bits; `overflow` = 0.
- Illegal opcode: `y` = 0, `carry` = `overflow` = 0, `illegal` = 1.
- For every opcode, `zero` = (`y`==0) and `negative` = `y[WIDTH-1]`; both are computed from the registered `y`.
- FSM states:
  - IDLE: `in_ready`=1, `out_valid`=0.
  - BUSY: MUL iterating; `in_ready`=0, `out_valid`=0.
  - DONE: `out_valid`=1; result and flags are held stable.
- Transitions:
  - IDLE or DONE, accepting a single-cycle op → DONE with the new result.
  - Accepting MUL → BUSY, with the iteration counter loaded to WIDTH−1.
  - BUSY → DONE when the counter reaches 0.
  - DONE with `out_ready`=1 and no accept → IDLE.
  - DONE with `out_ready`=0 → stays in DONE.
- An operation is accepted when `in_valid & in_ready`.
  - `in_ready` = (state==IDLE) | (state==DONE & `out_ready`). This gives one-per-cycle throughput for single-cycle ops.
- When the result drains and a new op is accepted in the same cycle, the new result replaces the old one in the same edge. `out_valid` stays 1.

## Timing
- Reset (`rst_n`=0 at a rising edge), effective at that edge from any state, including BUSY:
  - State → IDLE.
  - `out_valid`=0, `in_ready`=1.
  - `y`=0, `carry`=`overflow`=`negative`=`illegal`=0, `zero`=1.
  - Partial MUL state is discarded.
- Single-cycle ops accepted at edge N: `out_valid`=1 with the result after edge N.
- MUL accepted at edge N: `out_valid`=1 after edge N+WIDTH; `in_ready`=0 for the WIDTH cycles in between.
- While `out_valid`=1 and `out_ready`=0, all outputs are unchanged and `in_ready`=0.
- Inputs `a`, `b` and `op` are sampled only on the accepting edge; changes at any other time are ignored.
- No combinational path from `a`, `b` or `op` to any output. `in_ready` depends combinationally on `out_ready` only.

## Configuration
- `ALU_MUL_EN` defined:
  - The MUL datapath (accumulator, shifted multiplicand, counter) and the BUSY state are built.
  - Opcode A behaves as described in Operation.
- `ALU_MUL_EN` undefined:
  - None of that logic is instantiated.
  - Opcode A is illegal and completes in one cycle with `y`=0, `illegal`=1.

## Test plan
- ADD 0xFFFFFFFF+0x00000001 → one cycle later `y`=0, `carry`=1, `zero`=1, `overflow`=0.
- SUB 0x80000000−0x00000001 → `y`=0x7FFFFFFF, `overflow`=1, `carry`=1, `negative`=0.
- Shifts:
  - SRA 0x80000000 by 4 → 0xF8000000, `negative`=1, `carry`=0.
  - SLL 0x80000001 by 1 → 0x00000002, `carry`=1.
  - SLT 0xFFFFFFFF vs 0x1 → `y`=1; SLTU with the same operands → `y`=0.
- MUL (with `ALU_MUL_EN`):
  - 0x00010000×0x00010000 → `y`=0, `carry`=1, `zero`=1.
  - `out_valid` rises exactly 32 edges after accept; `in_ready`=0 throughout.
  - Without the macro, the same stimulus → `illegal`=1 after one cycle.
- Back-pressure: hold `out_ready`=0 for 3 cycles.
  - Outputs are stable and `in_ready`=0 throughout.
  - Then raise `out_ready` with `in_valid`=1 (XOR 0xF0F0F0F0,0xFFFFFFFF) → the next result 0x0F0F0F0F appears with no `out_valid` gap.
- Pull `rst_n` low mid-MUL → after that edge `out_valid`=0, `in_ready`=1, `zero`=1. Opcode 0xC → `illegal`=1, `y`=0.
